bp_cce_hybrid_req_dispatch: RTL and testbench
=============================================

Name: bp_cce_hybrid_req_dispatch

Overview:
- Stage directly downstream of the hybrid CCE pending-bit stage.
- Consumes the LCE request BedRock burst stream (header, then optional data beats) and routes each whole message to one of two consumers:
  - the uncached/IO handler (UC port);
  - the coherent directory pipeline (COH port).
- Limits outstanding UC messages with a credit counter.
- Raises a sticky error for cached-type requests to non-cacheable addresses; such requests are still routed to UC.

Parameters:
- bp_params_p, e_bp_default_cfg, processor config (paddr_width_p, lce/cce id widths, lce_assoc_p).
- lce_data_width_p, dword_width_gp, data beat width.
- cacheable_base_p, 'h8000_0000, addresses >= this value are cacheable.
- uc_credits_p, 4, maximum UC messages outstanding; counter width is BSG_SAFE_CLOG2(uc_credits_p+1).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- lce_req_header_i  in  lce_req_msg_header_width_lp  input header.
- lce_req_header_v_i / lce_req_header_ready_and_o  in/out  1  header handshake.
- lce_req_has_data_i  in  1  message carries data beats.
- lce_req_data_i  in  lce_data_width_p  data beat.
- lce_req_data_v_i / lce_req_data_ready_and_o  in/out  1  data handshake.
- lce_req_last_i  in  1  final beat.
- uc_header_o, uc_header_v_o, uc_header_ready_and_i, uc_has_data_o, uc_data_o, uc_data_v_o, uc_data_ready_and_i, uc_last_o  UC output burst; widths match the input.
- coh_header_o, coh_header_v_o, coh_header_ready_and_i, coh_has_data_o, coh_data_o, coh_data_v_o, coh_data_ready_and_i, coh_last_o  COH output burst; widths match the input.
- uc_done_i  in  1  UC handler retired one message; returns one credit.
- error_o  in/out: out  1  sticky misroute error.
- idle_o  out  1  FSM in e_ready and all credits returned.

Behaviour:
- Reset (async assert, sync deassert):
  - state = e_ready, route_r = COH, credits = uc_credits_p, error_o = 0.
  - All v_o and ready_and_o outputs = 0; data/header outputs = 0.
- Classification (combinational on lce_req_header_i):
  - is_uc_type = msg_type in {e_bedrock_req_uc_rd, e_bedrock_req_uc_wr, e_bedrock_req_uc_amo}.
  - noncacheable = addr < cacheable_base_p.
  - to_uc = is_uc_type | noncacheable.
  - misroute = ~is_uc_type & noncacheable.
- Passthrough is zero-latency: valid flows forward and ready flows backward combinationally. No storage other than the route and credit registers.
- e_ready:
  - If to_uc: uc_header_v_o = header_v_i & (credits != 0); header_ready_and_o = uc_header_ready_and_i & (credits != 0).
  - Otherwise: coh_header_v_o = header_v_i; header_ready_and_o = coh_header_ready_and_i.
  - Only the selected port sees valid; the other port's v_o = 0.
  - On a header handshake:
    - route_r captures to_uc.
    - If to_uc, credits decrement.
    - If misroute, error_o is set to 1 (sticky until reset).
    - If has_data, next state = e_data; otherwise stay in e_ready.
- e_data:
  - Data channel connects only to the port in route_r; header_ready_and_o = 0.
  - On a handshake where last_i = 1, return to e_ready.
- Credits:
  - uc_done_i increments the counter in the same cycle a UC header handshake decrements it, giving a net change of 0.
  - uc_done_i when credits == uc_credits_p is illegal; assert in simulation and saturate in RTL.
  - credits == 0 blocks only UC headers; COH headers proceed.
- A header never appears on an output before the previous message's last beat has transferred, so message order is preserved per port.
- Reset mid-burst returns the block to e_ready. Upstream and downstream blocks are reset together.

Optional Feature:
- Macro: BP_CCE_HYBRID_DISPATCH_STATS_EN.
- Defined: adds three 32-bit wrapping counters: uc_msgs, coh_msgs, uc_credit_stall_cycles. A stall cycle is header_v_i & to_uc & credits == 0 in e_ready. Counters are exposed on the output port stats_o (96 bits) and reset to 0.
- Undefined: no counters and no stats_o port; behaviour is otherwise identical.

Decomposition:
- bp_me_pkg holds:
  - the dispatch state enum (e_ready, e_data);
  - the route enum (e_route_coh = 0, e_route_uc = 1);
  - the function bp_cce_req_is_uc(msg_type).
- Sub-module bp_cce_hybrid_credit_counter (up/down saturating counter, full/empty outputs) for reuse by other hybrid stages.

Test Plan:
- Cached read, addr 'h8000_1000, no data → coh header handshake in the same cycle; uc_v = 0; credits stay 4; error_o = 0.
- UC write, addr 'h0010_0000, 2 beats → UC header, then 2 beats on uc_data with uc_last on beat 2; credits = 3; coh_v remains 0 throughout.
- Five UC reads with no uc_done_i → four accepted; fifth held with header_ready_and_o = 0; a cached read presented next still passes to COH; uc_done_i pulse → fifth accepted the next cycle.
- Cached write to addr 'h0000_2000 → routed to UC; error_o = 1 and stays 1 through ten later valid requests.
- Simultaneous uc_done_i and a UC header handshake at credits = 1 → credits stay 1.
- Assert reset_n_i low during beat 1 of a 2-beat COH write → all outputs 0 immediately; after release, idle_o = 1 and credits = 4.

Source files
------------

// File: rtl/bp_cce_hybrid_req_dispatch_pkg.sv
// Shared types for the hybrid CCE request dispatch stage.
//   - BedRock LCE request header layout and message type encodings
//   - dispatch FSM state and route enums
//   - bp_cce_req_is_uc(): uncached request-type classifier
//   - safe_clog2(): counter width helper that never returns 0
package bp_cce_hybrid_req_dispatch_pkg;

  localparam int unsigned paddr_width_gp   = 40;
  localparam int unsigned dword_width_gp   = 64;
  localparam int unsigned lce_id_width_gp  = 8;
  localparam int unsigned lce_assoc_gp     = 8;

  typedef enum logic [3:0] {
    e_bedrock_req_rd     = 4'd0,
    e_bedrock_req_wr     = 4'd1,
    e_bedrock_req_uc_rd  = 4'd2,
    e_bedrock_req_uc_wr  = 4'd3,
    e_bedrock_req_uc_amo = 4'd4
  } bp_bedrock_req_type_e;

  typedef struct packed {
    logic [lce_id_width_gp-1:0]      lce_id;
    logic [$clog2(lce_assoc_gp)-1:0] lru_way_id;
    logic                            non_exclusive;
    logic [3:0]                      pad;
  } bp_bedrock_req_payload_s;

  typedef struct packed {
    bp_bedrock_req_type_e        msg_type;
    logic [3:0]                  subop;
    logic [paddr_width_gp-1:0]   addr;
    logic [2:0]                  size;
    bp_bedrock_req_payload_s     payload;
  } bp_bedrock_req_header_s;

  localparam int unsigned lce_req_msg_header_width_lp = $bits(bp_bedrock_req_header_s);

  typedef enum logic {
    e_ready = 1'b0,
    e_data  = 1'b1
  } dispatch_state_e;

  typedef enum logic {
    e_route_coh = 1'b0,
    e_route_uc  = 1'b1
  } route_e;

  function automatic logic bp_cce_req_is_uc(bp_bedrock_req_type_e msg_type);
    return (msg_type == e_bedrock_req_uc_rd) || (msg_type == e_bedrock_req_uc_wr)
        || (msg_type == e_bedrock_req_uc_amo);
  endfunction

  function automatic int unsigned safe_clog2(int unsigned x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bp_cce_hybrid_credit_counter.sv
// Up/down saturating credit counter, resets to max_val_p (all credits available).
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   up_i             : return one credit (saturates at max_val_p)
//   down_i           : consume one credit (saturates at 0)
//   count_o          : credits currently available
//   full_o / empty_o : count_o == max_val_p / count_o == 0
module bp_cce_hybrid_credit_counter
  import bp_cce_hybrid_req_dispatch_pkg::*;
#(
  parameter int unsigned max_val_p = 4,
  parameter int unsigned width_p   = safe_clog2(max_val_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               up_i,
  input  logic               down_i,
  output logic [width_p-1:0] count_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam logic [width_p-1:0] MaxVal = width_p'(max_val_p);

  logic [width_p-1:0] count_q, count_d;

  assign full_o  = (count_q == MaxVal);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    // Simultaneous up and down cancel out.
    if (up_i && !down_i && !full_o) begin
      count_d = count_q + 1'b1;
    end else if (down_i && !up_i && !empty_o) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= MaxVal;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bp_cce_hybrid_req_dispatch.sv
// Hybrid CCE request dispatch: routes whole LCE request bursts (header + optional data
// beats) to either the uncached/IO handler (uc_*) or the coherent pipeline (coh_*).
// Zero-latency passthrough; only the route, FSM state, error flag and UC credits are stored.
// Ports:
//   clk_i, reset_n_i             : clock, asynchronous active-low reset
//   lce_req_*                    : input burst (header/has_data, data/last, ready-and handshakes)
//   uc_* / coh_*                 : output bursts, same layout as the input
//   uc_done_i                    : UC handler retired a message, returns one credit
//   error_o                      : sticky; cached-type request seen to a non-cacheable address
//   idle_o                       : no burst in flight and every UC credit returned
//   stats_o                      : {stall_cycles, coh_msgs, uc_msgs}, only with
//                                  BP_CCE_HYBRID_DISPATCH_STATS_EN defined
module bp_cce_hybrid_req_dispatch
  import bp_cce_hybrid_req_dispatch_pkg::*;
#(
  parameter int unsigned                  lce_data_width_p = dword_width_gp,
  parameter logic [paddr_width_gp-1:0]    cacheable_base_p = 40'h00_8000_0000,
  parameter int unsigned                  uc_credits_p     = 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,

  input  logic [lce_req_msg_header_width_lp-1:0] lce_req_header_i,
  input  logic                                   lce_req_header_v_i,
  output logic                                   lce_req_header_ready_and_o,
  input  logic                                   lce_req_has_data_i,
  input  logic [lce_data_width_p-1:0]            lce_req_data_i,
  input  logic                                   lce_req_data_v_i,
  output logic                                   lce_req_data_ready_and_o,
  input  logic                                   lce_req_last_i,

  output logic [lce_req_msg_header_width_lp-1:0] uc_header_o,
  output logic                                   uc_header_v_o,
  input  logic                                   uc_header_ready_and_i,
  output logic                                   uc_has_data_o,
  output logic [lce_data_width_p-1:0]            uc_data_o,
  output logic                                   uc_data_v_o,
  input  logic                                   uc_data_ready_and_i,
  output logic                                   uc_last_o,

  output logic [lce_req_msg_header_width_lp-1:0] coh_header_o,
  output logic                                   coh_header_v_o,
  input  logic                                   coh_header_ready_and_i,
  output logic                                   coh_has_data_o,
  output logic [lce_data_width_p-1:0]            coh_data_o,
  output logic                                   coh_data_v_o,
  input  logic                                   coh_data_ready_and_i,
  output logic                                   coh_last_o,

  input  logic                                   uc_done_i,
  output logic                                   error_o,
  output logic                                   idle_o
`ifdef BP_CCE_HYBRID_DISPATCH_STATS_EN
  ,
  output logic [95:0]                            stats_o
`endif
);

  localparam int unsigned CreditWidth = safe_clog2(uc_credits_p + 1);

  dispatch_state_e        state_q;
  route_e                 route_q;
  logic                   error_q;

  bp_bedrock_req_header_s hdr;
  logic                   is_uc_type, noncacheable, to_uc, misroute;
  logic                   hdr_hs, data_hs, credit_dec;
  logic                   credit_ok, credits_full, credits_empty;
  logic [CreditWidth-1:0] credits;

  assign hdr          = bp_bedrock_req_header_s'(lce_req_header_i);
  assign is_uc_type   = bp_cce_req_is_uc(hdr.msg_type);
  assign noncacheable = (hdr.addr < cacheable_base_p);
  assign to_uc        = is_uc_type | noncacheable;
  assign misroute     = ~is_uc_type & noncacheable;

  // Only msg_type and addr steer routing; the rest passes through untouched.
  logic unused_hdr_fields;
  assign unused_hdr_fields = ^{hdr.subop, hdr.size, hdr.payload};

  assign credit_ok  = ~credits_empty;
  assign hdr_hs     = lce_req_header_v_i & lce_req_header_ready_and_o;
  assign data_hs    = lce_req_data_v_i & lce_req_data_ready_and_o;
  assign credit_dec = hdr_hs & to_uc;

  bp_cce_hybrid_credit_counter #(
    .max_val_p (uc_credits_p),
    .width_p   (CreditWidth)
  ) u_credits (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .up_i      (uc_done_i),
    .down_i    (credit_dec),
    .count_o   (credits),
    .full_o    (credits_full),
    .empty_o   (credits_empty)
  );

  // Steering; everything is forced to zero while reset is asserted so downstream
  // sees a quiet interface even mid-burst.
  always_comb begin
    lce_req_header_ready_and_o = 1'b0;
    lce_req_data_ready_and_o   = 1'b0;
    uc_header_o    = '0;
    uc_header_v_o  = 1'b0;
    uc_has_data_o  = 1'b0;
    uc_data_o      = '0;
    uc_data_v_o    = 1'b0;
    uc_last_o      = 1'b0;
    coh_header_o   = '0;
    coh_header_v_o = 1'b0;
    coh_has_data_o = 1'b0;
    coh_data_o     = '0;
    coh_data_v_o   = 1'b0;
    coh_last_o     = 1'b0;
    if (reset_n_i) begin
      unique case (state_q)
        e_ready: begin
          if (to_uc) begin
            uc_header_o                = lce_req_header_i;
            uc_has_data_o              = lce_req_has_data_i;
            uc_header_v_o              = lce_req_header_v_i & credit_ok;
            lce_req_header_ready_and_o = uc_header_ready_and_i & credit_ok;
          end else begin
            coh_header_o               = lce_req_header_i;
            coh_has_data_o             = lce_req_has_data_i;
            coh_header_v_o             = lce_req_header_v_i;
            lce_req_header_ready_and_o = coh_header_ready_and_i;
          end
        end
        e_data: begin
          if (route_q == e_route_uc) begin
            uc_data_o                = lce_req_data_i;
            uc_data_v_o              = lce_req_data_v_i;
            uc_last_o                = lce_req_last_i;
            lce_req_data_ready_and_o = uc_data_ready_and_i;
          end else begin
            coh_data_o               = lce_req_data_i;
            coh_data_v_o             = lce_req_data_v_i;
            coh_last_o               = lce_req_last_i;
            lce_req_data_ready_and_o = coh_data_ready_and_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_ready;
      route_q <= e_route_coh;
      error_q <= 1'b0;
    end else begin
      unique case (state_q)
        e_ready: begin
          if (hdr_hs) begin
            route_q <= to_uc ? e_route_uc : e_route_coh;
            if (misroute) error_q <= 1'b1;
            if (lce_req_has_data_i) state_q <= e_data;
          end
        end
        e_data: begin
          if (data_hs && lce_req_last_i) state_q <= e_ready;
        end
        default: state_q <= e_ready;
      endcase
    end
  end

  assign error_o = error_q;
  assign idle_o  = reset_n_i & (state_q == e_ready) & credits_full;

  // A credit returned while none are outstanding means the UC handler and this
  // stage disagree about what is in flight.
  credit_overflow_a : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(uc_done_i && credits_full && !credit_dec));

`ifdef BP_CCE_HYBRID_DISPATCH_STATS_EN
  logic [31:0] uc_msgs_q, coh_msgs_q, stall_q;
  logic        stall;

  assign stall = (state_q == e_ready) & lce_req_header_v_i & to_uc & credits_empty;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      uc_msgs_q  <= '0;
      coh_msgs_q <= '0;
      stall_q    <= '0;
    end else begin
      if (hdr_hs && to_uc)  uc_msgs_q  <= uc_msgs_q + 32'd1;
      if (hdr_hs && !to_uc) coh_msgs_q <= coh_msgs_q + 32'd1;
      if (stall)            stall_q    <= stall_q + 32'd1;
    end
  end

  assign stats_o = {stall_q, coh_msgs_q, uc_msgs_q};
`endif

endmodule

// File: tb/tb_bp_cce_hybrid_req_dispatch.sv
// Directed bench for bp_cce_hybrid_req_dispatch. Inputs change 1ns after a rising edge,
// combinational outputs are checked 1ns later, state commits on the next rising edge.
module tb_bp_cce_hybrid_req_dispatch;
  import bp_cce_hybrid_req_dispatch_pkg::*;

  localparam int unsigned HW = lce_req_msg_header_width_lp;
  localparam int unsigned DW = dword_width_gp;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [HW-1:0] hdr;
  logic          hdr_v, hdr_rdy, has_data;
  logic [DW-1:0] data;
  logic          data_v, data_rdy, last;
  logic [HW-1:0] uc_hdr, coh_hdr;
  logic          uc_hdr_v, uc_hdr_rdy, uc_has_data, uc_data_v, uc_data_rdy, uc_last;
  logic          coh_hdr_v, coh_hdr_rdy, coh_has_data, coh_data_v, coh_data_rdy, coh_last;
  logic [DW-1:0] uc_data, coh_data;
  logic          uc_done, error, idle;
`ifdef BP_CCE_HYBRID_DISPATCH_STATS_EN
  logic [95:0]   stats;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bp_cce_hybrid_req_dispatch dut (
    .clk_i                      (clk),
    .reset_n_i                  (rst_n),
    .lce_req_header_i           (hdr),
    .lce_req_header_v_i         (hdr_v),
    .lce_req_header_ready_and_o (hdr_rdy),
    .lce_req_has_data_i         (has_data),
    .lce_req_data_i             (data),
    .lce_req_data_v_i           (data_v),
    .lce_req_data_ready_and_o   (data_rdy),
    .lce_req_last_i             (last),
    .uc_header_o                (uc_hdr),
    .uc_header_v_o              (uc_hdr_v),
    .uc_header_ready_and_i      (uc_hdr_rdy),
    .uc_has_data_o              (uc_has_data),
    .uc_data_o                  (uc_data),
    .uc_data_v_o                (uc_data_v),
    .uc_data_ready_and_i        (uc_data_rdy),
    .uc_last_o                  (uc_last),
    .coh_header_o               (coh_hdr),
    .coh_header_v_o             (coh_hdr_v),
    .coh_header_ready_and_i     (coh_hdr_rdy),
    .coh_has_data_o             (coh_has_data),
    .coh_data_o                 (coh_data),
    .coh_data_v_o               (coh_data_v),
    .coh_data_ready_and_i       (coh_data_rdy),
    .coh_last_o                 (coh_last),
    .uc_done_i                  (uc_done),
    .error_o                    (error),
    .idle_o                     (idle)
`ifdef BP_CCE_HYBRID_DISPATCH_STATS_EN
    ,
    .stats_o                    (stats)
`endif
  );

  function automatic logic [HW-1:0] mk_hdr(bp_bedrock_req_type_e t, logic [39:0] a);
    bp_bedrock_req_header_s h;
    h          = '0;
    h.msg_type = t;
    h.addr     = a;
    h.size     = 3'd3;
    h.payload  = 16'h05a5;
    return h;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; hdr = '0; hdr_v = 1'b0; has_data = 1'b0; data = '0; data_v = 1'b0;
    last = 1'b0; uc_done = 1'b0;
    uc_hdr_rdy = 1'b1; uc_data_rdy = 1'b1; coh_hdr_rdy = 1'b1; coh_data_rdy = 1'b1;

    // Reset: outputs quiet even with a request presented.
    repeat (2) @(posedge clk);
    #1;
    hdr = mk_hdr(e_bedrock_req_rd, 40'h00_8000_1000); hdr_v = 1'b1;
    #1;
    check("rst_coh_hdr_v", coh_hdr_v, 0);
    check("rst_hdr_rdy", hdr_rdy, 0);
    check("rst_coh_hdr", coh_hdr, 0);
    check("rst_error", error, 0);
    check("rst_idle", idle, 0);
    hdr_v = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    check("post_rst_idle", idle, 1);
    check("post_rst_credits", dut.credits, 4);

    // Cached read, no data: straight to COH.
    cyc();
    hdr = mk_hdr(e_bedrock_req_rd, 40'h00_8000_1000); hdr_v = 1'b1; has_data = 1'b0;
    #1;
    check("t1_coh_hdr_v", coh_hdr_v, 1);
    check("t1_hdr_rdy", hdr_rdy, 1);
    check("t1_uc_hdr_v", uc_hdr_v, 0);
    check("t1_coh_hdr", coh_hdr, mk_hdr(e_bedrock_req_rd, 40'h00_8000_1000));
    cyc();
    hdr_v = 1'b0;
    #1;
    check("t1_credits", dut.credits, 4);
    check("t1_error", error, 0);
    check("t1_idle", idle, 1);

    // UC write, 2 beats.
    hdr = mk_hdr(e_bedrock_req_uc_wr, 40'h00_0010_0000); hdr_v = 1'b1; has_data = 1'b1;
    #1;
    check("t2_uc_hdr_v", uc_hdr_v, 1);
    check("t2_uc_has_data", uc_has_data, 1);
    check("t2_coh_hdr_v", coh_hdr_v, 0);
    cyc();
    // A following cached header must wait for the burst to finish.
    hdr = mk_hdr(e_bedrock_req_rd, 40'h00_8000_4000); has_data = 1'b0;
    data = 64'h1111_2222_3333_4444; data_v = 1'b1; last = 1'b0;
    #1;
    check("t2_b1_uc_data_v", uc_data_v, 1);
    check("t2_b1_uc_data", uc_data, 64'h1111_2222_3333_4444);
    check("t2_b1_uc_last", uc_last, 0);
    check("t2_b1_data_rdy", data_rdy, 1);
    check("t2_b1_coh_data_v", coh_data_v, 0);
    check("t2_b1_hdr_rdy", hdr_rdy, 0);
    check("t2_b1_coh_hdr_v", coh_hdr_v, 0);
    cyc();
    data = 64'h5555_6666_7777_8888; last = 1'b1;
    #1;
    check("t2_b2_uc_data", uc_data, 64'h5555_6666_7777_8888);
    check("t2_b2_uc_last", uc_last, 1);
    check("t2_b2_coh_hdr_v", coh_hdr_v, 0);
    cyc();
    data_v = 1'b0; last = 1'b0; hdr_v = 1'b0;
    #1;
    check("t2_credits", dut.credits, 3);
    check("t2_idle", idle, 0);
    uc_done = 1'b1;
    cyc();
    uc_done = 1'b0;
    #1;
    check("t2_credits_ret", dut.credits, 4);

    // Five UC reads with no credit return.
    hdr = mk_hdr(e_bedrock_req_uc_rd, 40'h00_0010_0040); hdr_v = 1'b1; has_data = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t3_uc_accept", hdr_rdy, 1);
      cyc();
    end
    #1;
    check("t3_credits_zero", dut.credits, 0);
    check("t3_fifth_rdy", hdr_rdy, 0);
    check("t3_fifth_uc_v", uc_hdr_v, 0);
    cyc();
    check("t3_fifth_still_held", hdr_rdy, 0);
    hdr = mk_hdr(e_bedrock_req_rd, 40'h00_8000_3000);
    #1;
    check("t3_coh_bypass_v", coh_hdr_v, 1);
    check("t3_coh_bypass_rdy", hdr_rdy, 1);
    cyc();
    hdr = mk_hdr(e_bedrock_req_uc_rd, 40'h00_0010_0040); uc_done = 1'b1;
    #1;
    check("t3_done_cycle_rdy", hdr_rdy, 0);
    cyc();
    uc_done = 1'b0;
    #1;
    check("t3_after_done_credits", dut.credits, 1);
    check("t3_after_done_rdy", hdr_rdy, 1);
    check("t3_after_done_uc_v", uc_hdr_v, 1);
    cyc();
    hdr_v = 1'b0;
    #1;
    check("t3_final_credits", dut.credits, 0);

    // Simultaneous credit return and UC handshake at credits = 1.
    uc_done = 1'b1;
    cyc();
    uc_done = 1'b0;
    #1;
    check("t5_credits_one", dut.credits, 1);
    hdr_v = 1'b1; uc_done = 1'b1;
    #1;
    check("t5_hs_rdy", hdr_rdy, 1);
    cyc();
    hdr_v = 1'b0; uc_done = 1'b0;
    #1;
    check("t5_net_zero", dut.credits, 1);
    uc_done = 1'b1;
    repeat (3) cyc();
    uc_done = 1'b0;
    #1;
    check("t5_refill", dut.credits, 4);
    check("t5_idle", idle, 1);

    // Cached write to a non-cacheable address: misrouted to UC, sticky error.
    hdr = mk_hdr(e_bedrock_req_wr, 40'h00_0000_2000); hdr_v = 1'b1; has_data = 1'b1;
    #1;
    check("t4_uc_hdr_v", uc_hdr_v, 1);
    check("t4_coh_hdr_v", coh_hdr_v, 0);
    check("t4_error_before", error, 0);
    cyc();
    hdr_v = 1'b0; has_data = 1'b0; data = 64'hdead_beef_0000_0001; data_v = 1'b1; last = 1'b1;
    #1;
    check("t4_error_set", error, 1);
    check("t4_uc_data_v", uc_data_v, 1);
    check("t4_uc_last", uc_last, 1);
    cyc();
    data_v = 1'b0; last = 1'b0;
    // Lowest cacheable address upward stays on COH.
    for (int i = 0; i < 10; i++) begin
      hdr = mk_hdr(e_bedrock_req_rd, 40'h00_8000_0000 + 40'(i * 64)); hdr_v = 1'b1;
      #1;
      check("t4_coh_route", coh_hdr_v, 1);
      cyc();
      check("t4_error_sticky", error, 1);
    end
    hdr_v = 1'b0;
    uc_done = 1'b1;
    cyc();
    uc_done = 1'b0;
    #1;
    check("t4_credits_ret", dut.credits, 4);

    // Reset during beat 1 of a 2-beat COH write.
    hdr = mk_hdr(e_bedrock_req_wr, 40'h00_8000_2000); hdr_v = 1'b1; has_data = 1'b1;
    #1;
    check("t6_coh_hdr_v", coh_hdr_v, 1);
    cyc();
    hdr_v = 1'b0; has_data = 1'b0; data = 64'h0123_4567_89ab_cdef; data_v = 1'b1; last = 1'b0;
    #1;
    check("t6_b1_coh_data_v", coh_data_v, 1);
    check("t6_b1_coh_data", coh_data, 64'h0123_4567_89ab_cdef);
    rst_n = 1'b0;
    #1;
    check("t6_rst_coh_data_v", coh_data_v, 0);
    check("t6_rst_coh_data", coh_data, 0);
    check("t6_rst_data_rdy", data_rdy, 0);
    check("t6_rst_idle", idle, 0);
    check("t6_rst_error", error, 0);
    cyc();
    rst_n = 1'b1; data_v = 1'b0; data = '0;
    #1;
    check("t6_idle", idle, 1);
    check("t6_credits", dut.credits, 4);
    hdr = mk_hdr(e_bedrock_req_rd, 40'h00_9000_0000); hdr_v = 1'b1;
    #1;
    check("t6_ready_state_rdy", hdr_rdy, 1);
    check("t6_ready_state_coh_v", coh_hdr_v, 1);
    cyc();
    hdr_v = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
